alu_issue_stage: RTL and testbench

//  Producer side of the ALU operand/control interface: decodes an RV32I instruction plus

---
 rtl/alu_issue_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an RV32I instruction plus register-file read data into
// ALU operands and control, and holds them in a 2-entry skid buffer for the ALU stage.
module alu_issue_stage #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 6,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] srca,
  output logic [DATA_W-1:0] srcb,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              is_branch,
  output logic [DATA_W-1:0] br_target,
  output logic [4:0]        rd,
  output logic              rd_we,
  output logic              illegal
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_XOR  = 4'd2,  OP_SLL  = 4'd3,
    OP_SRL  = 4'd4,  OP_SRA  = 4'd5,  OP_AND  = 4'd6,  OP_OR   = 4'd7,
    OP_SLT  = 4'd8,  OP_BEQ  = 4'd9,  OP_BNE  = 4'd10, OP_BLT  = 4'd11,
    OP_BGE  = 4'd12, OP_SLTU = 4'd13, OP_BLTU = 4'd14, OP_BGEU = 4'd15
  } op_e;

  typedef enum logic [6:0] {
    OPC_R     = 7'b0110011,
    OPC_I     = 7'b0010011,
    OPC_B     = 7'b1100011,
    OPC_LUI   = 7'b0110111,
    OPC_AUIPC = 7'b0010111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] srca;
    logic [DATA_W-1:0] srcb;
    op_e               ctrl;
    logic              is_branch;
    logic [DATA_W-1:0] br_target;
    logic [4:0]        rd;
    logic              rd_we;
    logic              illegal;
  } payload_t;

  // funct3 map shared by R and I arithmetic; alt selects sub/sra
  function automatic op_e f3_to_op(input logic [2:0] f3, input logic alt);
    op_e op;
    op = OP_ADD;
    case (f3)
      3'b000: op = alt ? OP_SUB : OP_ADD;
      3'b001: op = OP_SLL;
      3'b010: op = OP_SLT;
      3'b011: op = OP_SLTU;
      3'b100: op = OP_XOR;
      3'b101: op = alt ? OP_SRA : OP_SRL;
      3'b110: op = OP_OR;
      3'b111: op = OP_AND;
    endcase
    return op;
  endfunction

  // funct3 map for conditional branches (010/011 handled as illegal by caller)
  function automatic op_e f3_to_br(input logic [2:0] f3);
    op_e op;
    op = OP_BEQ;
    case (f3)
      3'b000:  op = OP_BEQ;
      3'b001:  op = OP_BNE;
      3'b100:  op = OP_BLT;
      3'b101:  op = OP_BGE;
      3'b110:  op = OP_BLTU;
      3'b111:  op = OP_BGEU;
      default: op = OP_BEQ;
    endcase
    return op;
  endfunction

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [DATA_W-1:0] w_imm_i;
  logic [DATA_W-1:0] w_imm_b;
  logic [DATA_W-1:0] w_imm_u;
  logic [DATA_W-1:0] w_shamt;
  payload_t          w_dec;
  logic              w_in_fire;
  logic              w_drain;

  state_e   r_state;
  logic     r_out_valid;
  logic     r_in_ready;
  payload_t r_out;
  payload_t r_skid;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_u  = {instr[31:12], 12'b0};
  assign w_shamt  = DATA_W'(instr[24:20]);

  // Combinational decode of the offered beat
  always_comb begin
    w_dec       = '0;
    w_dec.ctrl  = OP_ADD;
    w_dec.rd    = instr[11:7];
    case (w_opcode)
      OPC_R: begin
        w_dec.srca = rs1_data;
        w_dec.srcb = rs2_data;
        w_dec.ctrl = f3_to_op(w_f3, instr[30]);
      end
      OPC_I: begin
        w_dec.srca = rs1_data;
        w_dec.srcb = ((w_f3 == 3'b001) || (w_f3 == 3'b101)) ? w_shamt : w_imm_i;
        w_dec.ctrl = f3_to_op(w_f3, (w_f3 == 3'b101) & instr[30]);
      end
      OPC_B: begin
        if ((w_f3 == 3'b010) || (w_f3 == 3'b011)) begin
          w_dec.illegal = 1'b1;
        end else begin
          w_dec.srca      = rs1_data;
          w_dec.srcb      = rs2_data;
          w_dec.ctrl      = f3_to_br(w_f3);
          w_dec.is_branch = 1'b1;
          w_dec.br_target = pc + w_imm_b;
        end
      end
      OPC_LUI: begin
        w_dec.srcb = w_imm_u;
      end
      OPC_AUIPC: begin
        w_dec.srca = pc;
        w_dec.srcb = w_imm_u;
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
    w_dec.rd_we = ~w_dec.illegal & ~w_dec.is_branch & (instr[11:7] != 5'd0);
  end

  assign in_ready  = (SKID_EN != 0) ? r_in_ready : (out_ready | ~r_out_valid);
  assign w_in_fire = in_valid & in_ready;
  assign w_drain   = r_out_valid & out_ready;

  // Output/skid holding FSM; flush wins over a same-cycle input beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out       <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && !w_drain) begin
            r_skid     <= w_dec;
            r_in_ready <= 1'b0;
            r_state    <= ST_TWO;
          end else if (w_in_fire) begin
            r_out <= w_dec;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            r_out      <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign srca      = r_out.srca;
  assign srcb      = r_out.srcb;
  assign alu_ctrl  = CTRL_W'(r_out.ctrl);
  assign is_branch = r_out.is_branch;
  assign br_target = r_out.br_target;
  assign rd        = r_out.rd;
  assign rd_we     = r_out.rd_we;
  assign illegal   = r_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed decode/handshake cases plus randomized
// traffic, checked by a negedge monitor against a queue-based reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [5:0]  alu_ctrl;
  logic        is_branch;
  logic [31:0] br_target;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;

  alu_issue_stage #(.DATA_W(32), .CTRL_W(6), .SKID_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .srca(srca), .srcb(srcb), .alu_ctrl(alu_ctrl), .is_branch(is_branch),
    .br_target(br_target), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [5:0]  ctrl;
    logic        br;
    logic [31:0] tgt;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } beat_t;

  localparam int R_TAB[8] = '{0, 3, 8, 13, 2, 4, 7, 6};
  localparam int B_TAB[8] = '{9, 10, -1, -1, 11, 12, 14, 15};

  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference decode from the instruction-set rules
  function automatic beat_t model(input logic [31:0] ins, input logic [31:0] p,
                                  input logic [31:0] a, input logic [31:0] b);
    beat_t e;
    int    f3;
    int    bimm;
    logic  alt;
    e    = '0;
    e.rd = ins[11:7];
    f3   = int'(ins[14:12]);
    alt  = ins[30];
    case (ins[6:0])
      7'b0110011: begin
        e.srca = a;
        e.srcb = b;
        e.ctrl = 6'(R_TAB[f3] + ((((f3 == 0) || (f3 == 5)) && alt) ? 1 : 0));
      end
      7'b0010011: begin
        e.srca = a;
        e.srcb = ((f3 == 1) || (f3 == 5)) ? 32'(ins[24:20]) : 32'($signed(ins) >>> 20);
        e.ctrl = 6'(R_TAB[f3] + (((f3 == 5) && alt) ? 1 : 0));
      end
      7'b1100011: begin
        if (B_TAB[f3] < 0) begin
          e.ill = 1'b1;
        end else begin
          bimm   = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
          e.srca = a;
          e.srcb = b;
          e.ctrl = 6'(B_TAB[f3]);
          e.br   = 1'b1;
          e.tgt  = p + 32'(bimm);
        end
      end
      7'b0110111: e.srcb = ins & 32'hFFFF_F000;
      7'b0010111: begin
        e.srca = p;
        e.srcb = ins & 32'hFFFF_F000;
      end
      default: e.ill = 1'b1;
    endcase
    e.we = !e.ill && !e.br && (e.rd != 5'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares handshake state and the head beat, then updates the model queue
  initial begin
    beat_t cur;
    forever begin
      @(negedge clk);
      cur = {srca, srcb, alu_ctrl, is_branch, br_target, rd, rd_we, illegal};
      if (!rst_n) begin
        sb.delete();
        chk("reset_state", {out_valid, in_ready, cur}, {1'b0, 1'b1, 110'b0});
      end else begin
        chk("out_valid", out_valid, sb.size() > 0);
        chk("in_ready", in_ready, sb.size() < 2);
        if (out_valid && sb.size() > 0) chk("payload", cur, sb[0]);
        if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(model(instr, pc, rs1_data, rs2_data));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string name);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    chk(name, acc, 1'b1);
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    instr    = i;
    pc       = p;
    rs1_data = a;
    rs2_data = b;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    drive(i, p, a, b);
    wait_accept("send_accept");
  endtask

  initial begin
    logic [6:0]  opcs[6];
    logic [31:0] t;
    opcs = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b0};

    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // sub x2,x1,x2
    send(32'h4020_8133, 32'h0, 32'd21, 32'd10);
    @(negedge clk);
    chk("t1_sub", {out_valid, alu_ctrl, srca, srcb, rd, rd_we},
        {1'b1, 6'd1, 32'd21, 32'd10, 5'd2, 1'b1});
    sync();

    // srai x5,x6,3
    send(32'h4033_5293, 32'h0, 32'h8000_0000, 32'h0);
    @(negedge clk);
    chk("t2_srai", {alu_ctrl, srca, srcb, rd, rd_we},
        {6'd5, 32'h8000_0000, 32'd3, 5'd5, 1'b1});
    sync();

    // addi x0,x0,5
    send(32'h0050_0013, 32'h0, 32'd7, 32'd0);
    @(negedge clk);
    chk("t2_addi_x0", {alu_ctrl, srcb, rd_we}, {6'd0, 32'd5, 1'b0});
    sync();

    // bgeu x1,x2,+16 at pc 0x100
    send(32'h0020_F863, 32'h100, 32'd7, 32'd9);
    @(negedge clk);
    chk("t3_bgeu", {alu_ctrl, is_branch, br_target, rd_we, illegal},
        {6'd15, 1'b1, 32'h110, 1'b0, 1'b0});
    sync();

    // branch with funct3=010
    send(32'h0020_A863, 32'h100, 32'd7, 32'd9);
    @(negedge clk);
    chk("t3_br_illegal", {out_valid, illegal, is_branch, rd_we}, 4'b1100);
    sync();

    // unknown opcode still flows
    send(32'hFFFF_FFFF, 32'h40, 32'd1, 32'd2);
    @(negedge clk);
    chk("t3_opc_illegal", {out_valid, illegal, alu_ctrl, srca, srcb},
        {1'b1, 1'b1, 6'd0, 32'd0, 32'd0});
    sync();

    // Backpressure: third beat must stall, then all drain in order
    out_ready = 1'b0;
    send(32'h0010_0093, 32'h0, 32'd1, 32'd0);
    send(32'h0020_0113, 32'h0, 32'd2, 32'd0);
    drive(32'h0030_0193, 32'h0, 32'd3, 32'd0);
    @(negedge clk);
    chk("t4_full", {out_valid, in_ready}, 2'b10);
    sync();
    out_ready = 1'b1;
    wait_accept("t4_third_accept");
    repeat (4) sync();
    @(negedge clk);
    chk("t4_drained", {out_valid, in_ready}, 2'b01);
    sync();

    // Flush in the full state with a beat offered
    out_ready = 1'b0;
    send(32'h0040_0213, 32'h0, 32'd4, 32'd0);
    send(32'h0050_0293, 32'h0, 32'd5, 32'd0);
    drive(32'h0060_0313, 32'h0, 32'd6, 32'd0);
    flush = 1'b1;
    sync();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_flush", {out_valid, in_ready}, 2'b01);
    sync();

    // Asynchronous reset between edges, then 1-cycle latency after release
    send(32'h0070_0393, 32'h0, 32'd7, 32'd0);
    send(32'h0080_0413, 32'h0, 32'd8, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", {out_valid, in_ready}, 2'b01);
    sync();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(32'h1234_5537, 32'h0, 32'd0, 32'd0);
    @(negedge clk);
    chk("t6_first_beat", {out_valid, alu_ctrl, srca, srcb, rd, rd_we},
        {1'b1, 6'd0, 32'd0, 32'h1234_5000, 5'd10, 1'b1});
    sync();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      t         = $urandom();
      opcs[5]   = 7'($urandom());
      instr     = {t[31:7], opcs[$urandom_range(0, 5)]};
      pc        = $urandom();
      rs1_data  = $urandom();
      rs2_data  = $urandom();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      sync();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) sync();
    @(negedge clk);
    chk("final_idle", {out_valid, in_ready}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
